regfile_sb: RTL

Parametrised integer register file with N combinational read ports, one write port with write-through bypass, and a per-register busy scoreboard. It replaces the fixed 32x32 two-read-port file in the decode stage. Decode gets same-cycle read data plus a per-port "operand pending" flag, so it can stall on RAW hazards without a separate hazard unit. The writeback stage drives the write port. Register 0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/regfile_sb.sv | 58 +++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file: default sizes, address
// width derivation and the register address type used by decode/writeback.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int addr_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  typedef logic [addr_w(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, with the
// completing write masked out of rd_busy in the same cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = addr_w(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      wa,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_rd,
  input  logic [NRD*AW-1:0]  rd_addr,
  output logic [NRD-1:0]     rd_busy,
  output logic [NREGS-1:0]   busy_vec
);

  logic [NREGS-1:0] busy;

  // The issue set is written last so a new producer outranks a completing one.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (we && wa != '0)
        busy[wa] <= 1'b0;
      if (iss_valid && iss_rd != '0)
        busy[iss_rd] <= 1'b1;
    end
  end

  assign busy_vec = busy;

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0] a;
    assign a = rd_addr[i*AW +: AW];
    assign rd_busy[i] = busy[a] && !(we && wa == a) && (a != '0) && !rst;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD combinational read ports, one write-through write
// port and a busy scoreboard for RAW hazard detection in decode.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREGS-1:0]    busy_vec
);

  logic [NREGS-1:0][XLEN-1:0] regs;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst)
      regs <= '0;
    else if (we && wa != '0)
      regs[wa] <= wd;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          byp;
    assign a   = rd_addr[i*AW +: AW];
    assign byp = we && (wa == a);
    assign rd_data[i*XLEN +: XLEN] = (rst || a == '0) ? '0 : (byp ? wd : regs[a]);
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wa        (wa),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .busy_vec  (busy_vec)
  );

endmodule
